// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the fetch/data memory arbiter.
// State encoding and default parameter values.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_I = 2'd1,
        WAIT_D = 2'd2
    } arbState_t;

    localparam int DEF_STARVE_LIMIT = 4;
    localparam int DEF_TIMEOUT      = 64;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational grant selector for the shared memory port.
// Data has priority unless fetch has been starved to the limit.
module mem_arb_pick (
    input  logic i_req,
    input  logic d_req,
    input  logic starve_at_limit,
    input  logic mem_Stall,
    output logic grant_i,
    output logic grant_d
);

    logic dWins;

    assign dWins   = d_req & ~(i_req & starve_at_limit);
    assign grant_d = ~mem_Stall & dWins;
    assign grant_i = ~mem_Stall & i_req & ~dWins;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported memory between fetch and data ports.
// Starvation counter bounds data priority; watchdog flags hung memory.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int TIMEOUT      = DEF_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic [15:0] i_data,
    output logic        i_done,
    output logic        i_stall,
    input  logic        d_rd,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    input  logic        d_dump,
    output logic [15:0] d_rdata,
    output logic        d_done,
    output logic        d_stall,
    output logic        mem_Rd,
    output logic        mem_Wr,
    output logic [15:0] mem_Addr,
    output logic [15:0] mem_DataIn,
    output logic        mem_createdump,
    input  logic [15:0] mem_DataOut,
    input  logic        mem_Done,
    input  logic        mem_Stall,
    output logic        err
);

    arbState_t   state;
    arbState_t   nextState;
    logic [3:0]  starveCnt;
    logic [7:0]  wdCnt;
    logic        dReq;
    logic        atLimit;
    logic        grantI;
    logic        grantD;
    logic        wdExpire;

    assign dReq     = d_rd | d_wr;
    assign atLimit  = (starveCnt == 4'(STARVE_LIMIT));
    assign wdExpire = (state != IDLE) & ~mem_Done
                    & (wdCnt == 8'(TIMEOUT - 1));

    mem_arb_pick uPick (
        .i_req           (i_req),
        .d_req           (dReq),
        .starve_at_limit (atLimit),
        .mem_Stall       (mem_Stall),
        .grant_i         (grantI),
        .grant_d         (grantD)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nextState;
    end

    // Next state: issue from IDLE unless hit, leave WAIT on done or expiry.
    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: begin
                if (grantI & ~mem_Done)      nextState = WAIT_I;
                else if (grantD & ~mem_Done) nextState = WAIT_D;
            end
            WAIT_I, WAIT_D: begin
                if (mem_Done | wdExpire) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Outputs: one-cycle strobes at issue, done pulses, address steering.
    always_comb begin
        mem_Rd     = 1'b0;
        mem_Wr     = 1'b0;
        i_done     = 1'b0;
        d_done     = 1'b0;
        mem_Addr   = i_addr;
        mem_DataIn = d_wdata;
        unique case (state)
            IDLE: begin
                mem_Addr = grantD ? d_addr : i_addr;
                mem_Rd   = ~rst & (grantI | (grantD & ~d_wr));
                mem_Wr   = ~rst & grantD & d_wr;
                i_done   = ~rst & grantI & mem_Done;
                d_done   = ~rst & grantD & mem_Done;
            end
            WAIT_I: begin
                mem_Addr = i_addr;
                i_done   = ~rst & mem_Done;
            end
            WAIT_D: begin
                mem_Addr = d_addr;
                d_done   = ~rst & mem_Done;
            end
            default: begin
                mem_Addr = i_addr;
            end
        endcase
    end

    // Starvation counter, wait-cycle watchdog and sticky error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starveCnt <= 4'd0;
            wdCnt     <= 8'd0;
            err       <= 1'b0;
        end else begin
            if (state == IDLE) begin
                wdCnt <= 8'd0;
                if (grantI | ~i_req)
                    starveCnt <= 4'd0;
                else if (grantD & ~atLimit)
                    starveCnt <= starveCnt + 4'd1;
            end else begin
                wdCnt <= wdCnt + 8'd1;
            end
            if (wdExpire) err <= 1'b1;
        end
    end

    assign i_data         = mem_DataOut;
    assign d_rdata        = mem_DataOut;
    assign i_stall        = i_req & ~i_done;
    assign d_stall        = dReq & ~d_done;
    assign mem_createdump = d_dump;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench plus directed scenarios for mem_arbiter.
// Fetch uses addresses 0x000-0x0FF, data 0x100-0x1FF, so bit 8 names the winner.
module tb_mem_arbiter;

    localparam int SL = 4;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req;
    logic [15:0] i_addr;
    logic [15:0] i_data;
    logic        i_done;
    logic        i_stall;
    logic        d_rd;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_wdata;
    logic        d_dump;
    logic [15:0] d_rdata;
    logic        d_done;
    logic        d_stall;
    logic        mem_Rd;
    logic        mem_Wr;
    logic [15:0] mem_Addr;
    logic [15:0] mem_DataIn;
    logic        mem_createdump;
    logic [15:0] mem_DataOut;
    logic        mem_Done;
    logic        mem_Stall;
    logic        err;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_data(i_data),
        .i_done(i_done), .i_stall(i_stall),
        .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr),
        .d_wdata(d_wdata), .d_dump(d_dump), .d_rdata(d_rdata),
        .d_done(d_done), .d_stall(d_stall),
        .mem_Rd(mem_Rd), .mem_Wr(mem_Wr), .mem_Addr(mem_Addr),
        .mem_DataIn(mem_DataIn), .mem_createdump(mem_createdump),
        .mem_DataOut(mem_DataOut), .mem_Done(mem_Done),
        .mem_Stall(mem_Stall), .err(err)
    );

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
    } txn_t;

    txn_t iq[$];
    txn_t dq[$];

    int checks = 0;
    int errors = 0;

    logic        dirMode;
    logic        dirDone;
    logic        dirStall;
    logic [15:0] dirOut;
    logic        chkEn;

    logic [15:0] memArr [0:511];
    logic [15:0] refMem [0:511];
    logic        busy;
    int          cnt;
    logic [15:0] latAddr;
    logic        hitNow;
    logic        rStall;
    logic        strobe;
    logic        mDone;
    logic [15:0] mOut;

    assign strobe      = mem_Rd | mem_Wr;
    assign mDone       = busy ? (cnt == 0) : (strobe & hitNow);
    assign mOut        = busy ? memArr[latAddr[8:0]] : memArr[mem_Addr[8:0]];
    assign mem_Done    = dirMode ? dirDone : mDone;
    assign mem_DataOut = dirMode ? dirOut : mOut;
    assign mem_Stall   = dirMode ? dirStall : rStall;

    task automatic chk1(string name, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk16(string name, logic [15:0] act, logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic fetchRun(int n);
        for (int k = 0; k < n; k++) begin
            int   gap;
            int   t;
            txn_t e;
            gap = $urandom_range(0, 3);
            i_req = 1'b0;
            repeat (gap) cyc();
            i_addr = 16'($urandom_range(0, 255));
            e.wr   = 1'b0;
            e.addr = i_addr;
            e.data = refMem[i_addr[8:0]];
            iq.push_back(e);
            i_req = 1'b1;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!i_done && t < 100);
            chk1("i_req_completes", i_done, 1'b1);
            cyc();
        end
        i_req = 1'b0;
    endtask

    task automatic dataRun(int n);
        for (int k = 0; k < n; k++) begin
            int   gap;
            int   op;
            int   t;
            txn_t e;
            gap = ($urandom_range(0, 3) == 0) ? 1 : 0;
            d_rd = 1'b0;
            d_wr = 1'b0;
            repeat (gap) cyc();
            op      = $urandom_range(0, 2);
            d_addr  = 16'h0100 | 16'($urandom_range(0, 255));
            d_wdata = 16'($urandom);
            d_rd    = (op != 1);
            d_wr    = (op != 0);
            e.wr    = d_wr;
            e.addr  = d_addr;
            if (d_wr) begin
                e.data = d_wdata;
                refMem[d_addr[8:0]] = d_wdata;
            end else begin
                e.data = refMem[d_addr[8:0]];
            end
            dq.push_back(e);
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!d_done && t < 100);
            chk1("d_req_completes", d_done, 1'b1);
            cyc();
        end
        d_rd = 1'b0;
        d_wr = 1'b0;
    endtask

    // Monitor/scoreboard and behavioural memory.
    initial begin
        logic        recSt;
        logic        recWr;
        logic        recDn;
        logic [15:0] recA;
        logic [15:0] recD;
        int          dWins;
        logic        iPend;
        logic        dPend;
        logic        gotD;
        logic        expD;
        txn_t        e;
        dWins  = 0;
        busy   = 1'b0;
        cnt    = 0;
        latAddr = 16'h0;
        hitNow = 1'b0;
        rStall = 1'b0;
        forever begin
            @(negedge clk);
            recSt = strobe;
            recWr = mem_Wr;
            recDn = mem_Done;
            recA  = mem_Addr;
            recD  = mem_DataIn;
            iPend = i_req;
            dPend = d_rd | d_wr;
            if (chkEn) begin
                if (strobe) begin
                    chk1("strobe_while_mem_stall", mem_Stall, 1'b0);
                    chk1("strobe_while_outstanding", busy, 1'b0);
                    chk1("both_strobes", mem_Rd & mem_Wr, 1'b0);
                    gotD = mem_Addr[8];
                    expD = dPend && !(iPend && dWins == SL);
                    chk1("grant_is_data", gotD, expD);
                    if (gotD && dq.size() > 0) begin
                        chk16("d_issue_addr", mem_Addr, dq[0].addr);
                        chk1("d_issue_wr", mem_Wr, dq[0].wr);
                        if (dq[0].wr)
                            chk16("d_issue_wdata", mem_DataIn, dq[0].data);
                    end else if (!gotD && iq.size() > 0) begin
                        chk16("i_issue_addr", mem_Addr, iq[0].addr);
                        chk1("i_issue_rd", mem_Rd, 1'b1);
                    end
                    if (!gotD)      dWins = 0;
                    else if (iPend) dWins = (dWins < SL) ? dWins + 1 : SL;
                    else            dWins = 0;
                end
                if (!iPend) dWins = 0;
                if (i_done) begin
                    if (iq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL i_done_unexpected actual=1 required=0");
                    end else begin
                        e = iq.pop_front();
                        chk16("i_data", i_data, e.data);
                    end
                end
                if (d_done) begin
                    if (dq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL d_done_unexpected actual=1 required=0");
                    end else begin
                        e = dq.pop_front();
                        if (!e.wr) chk16("d_rdata", d_rdata, e.data);
                    end
                end
            end
            @(posedge clk);
            #1;
            if (!dirMode) begin
                if (recSt && recWr) memArr[recA[8:0]] = recD;
                if (busy) begin
                    if (recDn) busy = 1'b0;
                    else       cnt--;
                end else if (recSt && !recDn) begin
                    busy    = 1'b1;
                    latAddr = recA;
                    cnt     = $urandom_range(0, 3);
                end
                hitNow = ($urandom_range(0, 2) == 0);
                rStall = !busy && ($urandom_range(0, 3) == 0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench timed out");
    end

    initial begin
        logic [15:0] v;
        for (int i = 0; i < 512; i++) begin
            v = 16'($urandom);
            memArr[i] = v;
            refMem[i] = v;
        end
        chkEn    = 1'b0;
        dirMode  = 1'b1;
        dirDone  = 1'b1;
        dirStall = 1'b0;
        dirOut   = 16'h0;
        rst      = 1'b1;
        i_req    = 1'b1;
        i_addr   = 16'h0040;
        d_rd     = 1'b0;
        d_wr     = 1'b1;
        d_addr   = 16'h0100;
        d_wdata  = 16'h0;
        d_dump   = 1'b0;
        repeat (2) @(negedge clk);
        chk1("rst_mem_Rd", mem_Rd, 1'b0);
        chk1("rst_mem_Wr", mem_Wr, 1'b0);
        chk1("rst_i_done", i_done, 1'b0);
        chk1("rst_d_done", d_done, 1'b0);
        chk1("rst_err", err, 1'b0);
        cyc();
        i_req   = 1'b0;
        d_wr    = 1'b0;
        dirDone = 1'b0;
        rst     = 1'b0;
        d_dump  = 1'b1;
        @(negedge clk);
        chk1("createdump_passthru", mem_createdump, 1'b1);
        cyc();
        d_dump  = 1'b0;
        dirMode = 1'b0;
        chkEn   = 1'b1;
        fork
            fetchRun(40);
            dataRun(40);
        join
        repeat (3) cyc();
        chkEn = 1'b0;
        chk16("queues_drained", 16'(iq.size() + dq.size()), 16'h0);
        chk1("no_err_random", err, 1'b0);
        dirMode = 1'b1;
        dirDone = 1'b0;
        dirStall = 1'b0;

        // fetch only, done three cycles after issue
        cyc();
        i_addr = 16'h0040;
        i_req  = 1'b1;
        @(negedge clk);
        chk1("t1_issue_rd", mem_Rd, 1'b1);
        chk16("t1_addr", mem_Addr, 16'h0040);
        chk1("t1_stall", i_stall, 1'b1);
        cyc();
        @(negedge clk);
        chk1("t1_wait_no_rd", mem_Rd, 1'b0);
        chk16("t1_wait_addr", mem_Addr, 16'h0040);
        cyc();
        @(negedge clk);
        chk1("t1_wait_no_done", i_done, 1'b0);
        cyc();
        dirDone = 1'b1;
        dirOut  = 16'hBEEF;
        @(negedge clk);
        chk1("t1_done", i_done, 1'b1);
        chk16("t1_data", i_data, 16'hBEEF);
        chk1("t1_stall_at_done", i_stall, 1'b0);
        cyc();
        i_req   = 1'b0;
        dirDone = 1'b0;
        @(negedge clk);
        chk1("t1_after_stall", i_stall, 1'b0);
        chk1("t1_after_done", i_done, 1'b0);

        // simultaneous fetch and data write
        cyc();
        i_req   = 1'b1;
        d_wr    = 1'b1;
        d_addr  = 16'h0100;
        d_wdata = 16'h1234;
        @(negedge clk);
        chk1("t2_wr", mem_Wr, 1'b1);
        chk1("t2_no_rd", mem_Rd, 1'b0);
        chk16("t2_addr", mem_Addr, 16'h0100);
        chk16("t2_wdata", mem_DataIn, 16'h1234);
        chk1("t2_i_stall", i_stall, 1'b1);
        chk1("t2_d_stall", d_stall, 1'b1);
        cyc();
        dirDone = 1'b1;
        @(negedge clk);
        chk1("t2_d_done", d_done, 1'b1);
        chk1("t2_no_i_done", i_done, 1'b0);
        chk1("t2_wait_no_wr", mem_Wr, 1'b0);
        cyc();
        d_wr    = 1'b0;
        dirDone = 1'b0;
        @(negedge clk);
        chk1("t2_fetch_issue", mem_Rd, 1'b1);
        chk16("t2_fetch_addr", mem_Addr, 16'h0040);
        cyc();
        dirDone = 1'b1;
        dirOut  = 16'h5A5A;
        @(negedge clk);
        chk1("t2_i_done", i_done, 1'b1);
        chk16("t2_i_data", i_data, 16'h5A5A);

        // same-cycle hit
        cyc();
        i_req  = 1'b0;
        d_rd   = 1'b1;
        d_addr = 16'h0100;
        dirDone = 1'b1;
        dirOut  = 16'h1111;
        @(negedge clk);
        chk1("t3_rd", mem_Rd, 1'b1);
        chk1("t3_hit_done", d_done, 1'b1);
        chk16("t3_hit_data", d_rdata, 16'h1111);
        chk1("t3_hit_stall", d_stall, 1'b0);
        cyc();
        d_addr  = 16'h0102;
        dirDone = 1'b0;
        @(negedge clk);
        chk1("t3_next_issue", mem_Rd, 1'b1);
        chk16("t3_next_addr", mem_Addr, 16'h0102);
        chk1("t3_next_no_done", d_done, 1'b0);
        cyc();
        dirDone = 1'b1;
        dirOut  = 16'h2222;
        @(negedge clk);
        chk1("t3_miss_done", d_done, 1'b1);
        chk16("t3_miss_data", d_rdata, 16'h2222);

        // starvation bound: D,D,D,D,I repeating
        cyc();
        d_addr  = 16'h0100;
        i_addr  = 16'h0040;
        i_req   = 1'b1;
        d_rd    = 1'b1;
        dirDone = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk1("t4_fetch_grant", i_done, (k % 5) == 4);
            chk1("t4_data_grant", d_done, (k % 5) != 4);
            cyc();
        end

        // watchdog expiry on a fetch
        d_rd    = 1'b0;
        dirDone = 1'b0;
        @(negedge clk);
        chk1("t5_issue", mem_Rd, 1'b1);
        for (int w = 1; w <= TO; w++) begin
            cyc();
            @(negedge clk);
            chk1("t5_wait_err", err, 1'b0);
            chk1("t5_wait_done", i_done, 1'b0);
            chk1("t5_wait_rd", mem_Rd, 1'b0);
        end
        cyc();
        @(negedge clk);
        chk1("t5_err", err, 1'b1);
        chk1("t5_reissue", mem_Rd, 1'b1);
        chk1("t5_no_done", i_done, 1'b0);
        chk1("t5_still_stalled", i_stall, 1'b1);
        cyc();
        dirDone = 1'b1;
        dirOut  = 16'hCAFE;
        @(negedge clk);
        chk1("t5_late_done", i_done, 1'b1);
        chk16("t5_late_data", i_data, 16'hCAFE);
        cyc();
        i_req   = 1'b0;
        dirDone = 1'b0;
        @(negedge clk);
        chk1("t5_err_sticky", err, 1'b1);

        // reset in WAIT_D, then memory stall after reset
        cyc();
        d_rd   = 1'b1;
        d_addr = 16'h0100;
        @(negedge clk);
        chk1("t6_issue", mem_Rd, 1'b1);
        cyc();
        cyc();
        rst     = 1'b1;
        dirDone = 1'b1;
        @(negedge clk);
        chk1("t6_rst_d_done", d_done, 1'b0);
        chk1("t6_rst_err", err, 1'b0);
        chk1("t6_rst_rd", mem_Rd, 1'b0);
        cyc();
        rst      = 1'b0;
        dirStall = 1'b1;
        dirDone  = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            chk1("t6_stall_no_rd", mem_Rd, 1'b0);
            chk1("t6_stall_no_done", d_done, 1'b0);
            cyc();
        end
        dirStall = 1'b0;
        @(negedge clk);
        chk1("t6_issue_after_stall", mem_Rd, 1'b1);
        chk16("t6_issue_addr", mem_Addr, 16'h0100);
        cyc();
        dirDone = 1'b1;
        @(negedge clk);
        chk1("t6_done", d_done, 1'b1);
        cyc();
        d_rd    = 1'b0;
        dirDone = 1'b0;
        repeat (2) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-ported mem_system instance between the fetch stage (instruction reads) and the memory stage (data reads, writes, dumps).
- Sequences each access as a request/Done transaction.
- Returns per-requester stall, done and read data.
- Data port has fixed priority, bounded by a starvation limit so fetch always progresses; a watchdog flags a hung memory.

Parameters:
STARVE_LIMIT, 4, consecutive data grants allowed while i_req is pending before fetch is forced to win; range 1..15
TIMEOUT, 64, cycles in a wait state without mem_Done before err is raised; range 2..255

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
i_req  in  1  fetch read request, held until i_done
i_addr  in  16  fetch address
i_data  out  16  fetch read data, valid with i_done
i_done  out  1  fetch transaction complete
i_stall  out  1  fetch must hold/freeze
d_rd  in  1  data read request, held until d_done
d_wr  in  1  data write request, held until d_done
d_addr  in  16  data address
d_wdata  in  16  write data
d_dump  in  1  createdump request, passed through
d_rdata  out  16  data read data, valid with d_done
d_done  out  1  data transaction complete
d_stall  out  1  memory stage must hold/freeze
mem_Rd  out  1  memory read strobe
mem_Wr  out  1  memory write strobe
mem_Addr  out  16  memory address
mem_DataIn  out  16  memory write data
mem_createdump  out  1  equals d_dump
mem_DataOut  in  16  memory read data
mem_Done  in  1  memory completion
mem_Stall  in  1  memory busy, no new request accepted
err  out  1  sticky watchdog error

Behaviour:
- Reset (async, any state): state=IDLE, starve_cnt=0, wd_cnt=0, err=0. All strobes and done outputs are 0 while rst is high.
- States: IDLE, WAIT_I, WAIT_D.
- IDLE, arbitration:
  - Eligible only if mem_Stall=0.
  - Data wins if d_rd|d_wr, unless i_req=1 and starve_cnt==STARVE_LIMIT; otherwise fetch wins if i_req.
  - The winner drives mem_Rd/mem_Wr/mem_Addr/mem_DataIn combinationally in that same issue cycle, for exactly 1 cycle.
  - d_rd&d_wr together is treated as a write.
- Same-cycle hit: if mem_Done=1 in the issue cycle, the transaction completes immediately and the state stays IDLE.
- Otherwise the next state is WAIT_I or WAIT_D.
- WAIT_x:
  - Strobes are 0; mem_Addr/mem_DataIn hold the granted requester's values.
  - On mem_Done, x_done=1 the same cycle, x_data=mem_DataOut (combinational), next state IDLE.
  - Minimum inter-transaction gap for a miss: issue, wait(s), done, then IDLE re-issue next cycle.
- Done/data: i_done/d_done are single-cycle pulses. They are asserted regardless of whether the requester still holds the request (a dropped request is completed and discarded). i_data/d_rdata are don't-care when done=0.
- Stalls (combinational):
  - i_stall = i_req & ~i_done.
  - d_stall = (d_rd|d_wr) & ~d_done.
- starve_cnt:
  - +1 (saturating at STARVE_LIMIT) on each data grant while i_req=1.
  - Cleared on a fetch grant, or any IDLE cycle with i_req=0.
- Watchdog:
  - wd_cnt counts cycles in WAIT_x; cleared on entry to WAIT_x.
  - At wd_cnt==TIMEOUT-1 with no mem_Done: err<=1 (sticky until rst), state→IDLE, no done pulse.
  - The requester is still stalled and is re-arbitrated.
- Simultaneous events:
  - mem_Done in the watchdog expiry cycle counts as a normal completion, with no err.
  - Requests arriving while in WAIT_x wait for IDLE.
- Address/data are not registered by the arbiter; requesters hold them stable until done.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, WAIT_I=2'd1, WAIT_D=2'd2), default STARVE_LIMIT and TIMEOUT.
- One natural sub-module: mem_arb_pick, the combinational grant selector (inputs i_req, d_req, starve_at_limit, mem_Stall; outputs grant_i, grant_d).
- Counters and FSM live in the top level.

Test Plan:
- Fetch-only, memory Done 3 cycles after issue, i_addr=16'h0040, mem_DataOut=16'hBEEF → mem_Rd 1 cycle, i_done at cycle 3 with i_data=16'hBEEF, i_stall low the next cycle.
- i_req and d_wr (d_addr=16'h0100, d_wdata=16'h1234) asserted together → data granted first with mem_Wr=1 and mem_DataIn=16'h1234; fetch is issued the cycle after d_done.
- Same-cycle hit: mem_Done=1 in the issue cycle for d_rd → d_done in the issue cycle, state stays IDLE, next request issues the following cycle.
- Starvation, STARVE_LIMIT=4, d_rd held continuously with i_req high → grants D,D,D,D,I,D…; starve_cnt returns to 0 after the fetch grant.
- Watchdog, TIMEOUT=8, mem_Done never asserted after a fetch issue → err=1 on the 8th WAIT_I cycle, no i_done, fetch re-issued from IDLE; err stays 1 until rst.
- Reset mid-WAIT_D → state IDLE, err=0, no d_done. With mem_Stall=1 after reset, no strobe is issued until mem_Stall=0.
